// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - dmem responder: word RAM plus GPIO, cycle counter and timer MMIO
// Define DMEM_MMIO_TIMER_EN to build the down-counting timer at 0xF03..0xF05.
module dmem_mmio_responder #(
  parameter int RAM_WORDS = 1024,
  parameter int GPIO_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [11:0]       address,
  input  logic [31:0]       data,
  input  logic              wren,
  output logic [31:0]       q,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              irq
);
  localparam int          AW          = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [11:0] RAM_END     = 12'(RAM_WORDS);
  localparam logic [11:0] A_GPIO_OUT  = 12'hF00;
  localparam logic [11:0] A_GPIO_IN   = 12'hF01;
  localparam logic [11:0] A_CYCLE     = 12'hF02;
  localparam logic [11:0] A_TLOAD     = 12'hF03;
  localparam logic [11:0] A_TCTRL     = 12'hF04;
  localparam logic [11:0] A_TCOUNT    = 12'hF05;

  logic [31:0]       mem [RAM_WORDS];
  logic [31:0]       q_q, q_d;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [31:0]       cycle_q, cycle_d;
  logic              ram_hit;
  logic [AW-1:0]     ram_idx;
  logic [31:0]       tload_rd, tctrl_rd, tcount_rd;
  logic              irq_rd;

  assign ram_hit = address < RAM_END;
  assign ram_idx = address[AW-1:0];

  // RAM has no reset: contents survive a processor reset.
  always_ff @(posedge clock) begin
    if (wren && ram_hit) mem[ram_idx] <= data;
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    if (wren && address == A_GPIO_OUT) gpio_out_d = data[GPIO_W-1:0];
    sync1_d = gpio_in;
    sync2_d = sync1_q;
    cycle_d = cycle_q + 32'd1;
  end

`ifdef DMEM_MMIO_TIMER_EN
  logic [31:0] tload_q, tload_d, tcount_q, tcount_d;
  logic        en_q, en_d, ar_q, ar_d, tirq_q, tirq_d;
  logic        expire;

  assign expire = en_q && (tcount_q == 32'd1);

  always_comb begin
    tload_d  = tload_q;
    tcount_d = tcount_q;
    en_d     = en_q;
    ar_d     = ar_q;
    tirq_d   = tirq_q;
    if (en_q) begin
      if (tcount_q > 32'd1) begin
        tcount_d = tcount_q - 32'd1;
      end else if (expire) begin
        if (ar_q) begin
          tcount_d = tload_q;
        end else begin
          tcount_d = 32'd0;
          en_d     = 1'b0;
        end
      end
    end
    // Software writes override the countdown; an expiry beats a W1C in the same cycle.
    if (wren && address == A_TLOAD) begin
      tload_d  = data;
      tcount_d = data;
    end
    if (wren && address == A_TCTRL) begin
      en_d = data[0];
      ar_d = data[1];
      if (data[2]) tirq_d = 1'b0;
    end
    if (expire) tirq_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tload_q  <= 32'd0;
      tcount_q <= 32'd0;
      en_q     <= 1'b0;
      ar_q     <= 1'b0;
      tirq_q   <= 1'b0;
    end else begin
      tload_q  <= tload_d;
      tcount_q <= tcount_d;
      en_q     <= en_d;
      ar_q     <= ar_d;
      tirq_q   <= tirq_d;
    end
  end

  assign tload_rd  = tload_q;
  assign tctrl_rd  = {29'd0, tirq_q, ar_q, en_q};
  assign tcount_rd = tcount_q;
  assign irq_rd    = tirq_q;
`else
  assign tload_rd  = 32'd0;
  assign tctrl_rd  = 32'd0;
  assign tcount_rd = 32'd0;
  assign irq_rd    = 1'b0;
`endif

  // Read mux sees pre-edge state, which gives read-first behaviour everywhere.
  always_comb begin
    q_d = 32'd0;
    if (ram_hit) begin
      q_d = mem[ram_idx];
    end else begin
      case (address)
        A_GPIO_OUT: q_d = 32'(gpio_out_q);
        A_GPIO_IN:  q_d = 32'(sync2_q);
        A_CYCLE:    q_d = cycle_q;
        A_TLOAD:    q_d = tload_rd;
        A_TCTRL:    q_d = tctrl_rd;
        A_TCOUNT:   q_d = tcount_rd;
        default:    q_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      q_q        <= 32'd0;
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cycle_q    <= 32'd0;
    end else begin
      q_q        <= q_d;
      gpio_out_q <= gpio_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cycle_q    <= cycle_d;
    end
  end

  assign q        = q_q;
  assign gpio_out = gpio_out_q;
  assign irq      = irq_rd;

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder end of the processor's data-memory bus: services the processor's `address`/`data`/`wren` requests and returns `q`, replacing the bare dmem syncram.
- Word-addressed RAM plus a small memory-mapped I/O window: GPIO out/in, a free-running cycle counter, and a down-counting timer with interrupt.
- Timing matches the syncram it replaces (registered read, one-cycle latency), so the processor's dmem timing is unchanged.
- Runs on the dmem clock domain.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words; legal 1..3840.
- GPIO_W, 16, width of gpio_out and gpio_in.

Ports:
- clock  input  1  dmem clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
- address  input  12  word address from processor.
- data  input  32  store data from processor.
- wren  input  1  store enable; write occurs on the rising edge where wren=1.
- q  output  32  registered read data.
- gpio_out  output  GPIO_W  GPIO output register.
- gpio_in  input  GPIO_W  asynchronous external inputs.
- irq  output  1  timer interrupt level; equals TIMER_CTRL.bit2.

Behaviour:
- Reset (reset=0 at an edge) clears:
  - q, gpio_out, CYCLE, TIMER_LOAD, TIMER_COUNT, TIMER_CTRL, and both gpio_in sync stages, all to 0.
  - irq goes to 0.
  - RAM contents are not cleared.
  - Reset mid-timer-countdown: timer stops and the pending irq is dropped.
- Address map (word addresses):
  - 0x000..RAM_WORDS-1: RAM, read/write.
  - RAM_WORDS..0xEFF: unmapped; reads return 0, writes are ignored.
  - 0xF00 GPIO_OUT: RW; bits above GPIO_W read 0.
  - 0xF01 GPIO_IN: RO; value after a 2-flop synchronizer, zero-extended.
  - 0xF02 CYCLE: RO; increments every non-reset cycle, wraps 0xFFFFFFFF -> 0.
  - 0xF03 TIMER_LOAD: RW; a write also loads TIMER_COUNT with the same value.
  - 0xF04 TIMER_CTRL: bit0 EN, bit1 AUTORELOAD (both RW); bit2 IRQ, write-1-to-clear; bits 31:3 read 0.
  - 0xF05 TIMER_COUNT: RO.
  - 0xF06..0xFFF: read 0, writes ignored.
  - Writes to read-only registers are ignored.
- Read timing:
  - q is updated every cycle with the contents of the location addressed in the previous cycle; latency is exactly 1 clock.
  - Read and write to the same location in the same cycle: q returns the old value (read-first). This applies to RAM and MMIO alike.
  - CYCLE read: q holds CYCLE's pre-edge value at the sampling edge.
- Timer (when EN=1), evaluated each cycle:
  - TIMER_COUNT > 1: decrement.
  - TIMER_COUNT == 1: set IRQ. If AUTORELOAD=1, count := TIMER_LOAD; otherwise count := 0 and EN is cleared by hardware.
  - TIMER_COUNT == 0: hold, no IRQ.
  - EN=0: count holds.
- Timer simultaneous events:
  - A TIMER_LOAD write in the same cycle as a decrement: the write wins.
  - A TIMER_CTRL write carrying bit2=1 in the same cycle as an expiry: IRQ stays set (set wins).
  - A TIMER_CTRL write that sets EN updates the control bits only; count starts decrementing the next cycle.
- All arithmetic is unsigned 32-bit modulo 2^32.

Optional Feature:
- Macro DMEM_MMIO_TIMER_EN.
- Defined: TIMER_LOAD, TIMER_CTRL and TIMER_COUNT are implemented as described.
- Undefined: 0xF03..0xF05 behave as unmapped (read 0, writes ignored), irq is tied to 0, and no timer flops are synthesized.
- RAM, GPIO and CYCLE are identical in both builds.

Test Plan:
- Store 0xDEADBEEF @0x010, then read 0x010 the next cycle -> q=0xDEADBEEF one edge after the address is presented. Read 0x500 (RAM_WORDS=1024) -> q=0. A store to 0x500 followed by a read -> still 0.
- Same-cycle write 0x11111111 / read @0x020 holding 0x22222222 -> q=0x22222222 that cycle, then 0x11111111 on the next read.
- gpio_in=0x00A5 -> a read of 0xF01 returns 0x000000A5 no earlier than 2 cycles after the change. Store 0x1234FFFF to 0xF00 -> gpio_out=0xFFFF; read-back returns 0x0000FFFF.
- Release reset, wait 10 cycles, read 0xF02 -> q=10 (±1 per documented sampling edge). Force CYCLE to 0xFFFFFFFF via a long run or a bench backdoor -> next value is 0.
- TIMER_LOAD=3, CTRL=0x3 -> count sequence 3,2,1 then reload to 3; IRQ and irq=1 after the third enabled cycle. Write CTRL=0x7 on the same cycle as the next expiry -> IRQ remains 1. Write CTRL=0x4 on a non-expiry cycle -> irq=0.
- Assert reset=0 mid-countdown with irq=1 -> next edge: count=0, irq=0, q=0, gpio_out=0. Repeat the timer test with DMEM_MMIO_TIMER_EN undefined -> reads of 0xF03..0xF05 return 0 and irq stays 0.
